cdf_scale_div_engine: RTL and testbench

//  Multi-lane successor to the histogram-equalisation divider. Streams a block of packed CDF words

---
 rtl/cdf_scale_div_engine.sv | 208 ++++++++++++++++++++
 tb/tb_cdf_scale_div_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdf_scale_div_engine.sv
// cdf_scale_div_engine
//   Streams a block of packed CDF words from scratch memory, maps every lane to
//   (cdf - cdf_min) * MAX_LEVEL / (cdf_total - cdf_min) with a restoring divider
//   (all lanes in parallel, one quotient bit per cycle), and writes the result
//   words back to scratch memory.
//
// Ports
//   clk, reset               clock (rising edge), asynchronous active-high reset
//   enable                   start request, rising edge accepted only when idle
//   cdf_min, cdf_total       scaling bounds, latched at accept
//   src_base, dst_base       first source / destination word address, latched
//   num_words                words to process (0 legal), latched
//   rd_addr / rd_data        scratch read port, data valid RD_LAT cycles later
//   wt_addr / wt_data / wt_en scratch write port, one strobe per word
//   busy, done               job in progress (accept..done), end-of-job pulse
//
// state  | meaning
// S_IDLE | waiting for an enable rising edge
// S_RD   | rd_addr holds the current source word
// S_WAIT | covering memory read latency (RD_LAT cycles)
// S_PREP | per-lane clamp checks, numerator/denominator set-up
// S_DIV  | OUT_W restoring-division steps, MSB first
// S_WR   | wt_en high for the finished word
// S_DONE | done pulse, then back to idle
module cdf_scale_div_engine #(
  parameter int LANES     = 4,
  parameter int LANE_W    = 32,
  parameter int OUT_W     = 8,
  parameter int MAX_LEVEL = 255,
  parameter int ADDR_W    = 16,
  parameter int RD_LAT    = 0,
  parameter int ROUND     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [LANE_W-1:0]       cdf_min,
  input  logic [LANE_W-1:0]       cdf_total,
  input  logic [ADDR_W-1:0]       src_base,
  input  logic [ADDR_W-1:0]       dst_base,
  input  logic [ADDR_W-1:0]       num_words,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [LANES*LANE_W-1:0] rd_data,
  output logic [ADDR_W-1:0]       wt_addr,
  output logic [LANES*LANE_W-1:0] wt_data,
  output logic                    wt_en,
  output logic                    busy,
  output logic                    done
);

  localparam int NW = LANE_W + OUT_W + 1;
  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [NW-1:0]    ML_N = NW'(MAX_LEVEL);
  localparam logic [OUT_W-1:0] ML_Q = OUT_W'(MAX_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WAIT, S_PREP, S_DIV, S_WR, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic                    en_q;
  logic                    start;
  logic [LANE_W-1:0]       min_q, tot_q;
  logic [ADDR_W-1:0]       rd_addr_q, wt_addr_q, dst_q, words_q;
  logic [WW-1:0]           wait_q;
  logic [CW-1:0]           div_q;
  logic [LANES*LANE_W-1:0] data_q, wt_data_q;
  logic [NW-1:0]           rem_q [LANES];
  logic [NW-1:0]           dsh_q [LANES];
  logic [OUT_W-1:0]        quo_q [LANES];

  logic [LANE_W-1:0]       den_w;
  logic [NW-1:0]           prep_rem [LANES];
  logic [NW-1:0]           prep_dsh [LANES];
  logic [OUT_W-1:0]        q_nxt [LANES];
  logic [LANES-1:0]        ge;

  function automatic logic [OUT_W-1:0] sat_q(input logic [OUT_W-1:0] q);
    return (q > ML_Q) ? ML_Q : q;
  endfunction

  assign start = enable & ~en_q;
  assign den_w = tot_q - min_q;

  // Clamped lanes are turned into trivial divisions (0/1 or MAX_LEVEL/1) so the
  // divider never sees a zero denominator and needs no per-lane bypass.
  // The divisor register starts at den << (OUT_W-1) and halves every step.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prep_rem[l] = '0;
      prep_dsh[l] = NW'(1) << (OUT_W - 1);
      if (data_q[l*LANE_W +: LANE_W] <= min_q) begin
        prep_rem[l] = '0;
      end else if (data_q[l*LANE_W +: LANE_W] >= tot_q) begin
        prep_rem[l] = ML_N;
      end else begin
        prep_rem[l] = NW'(data_q[l*LANE_W +: LANE_W] - min_q) * ML_N
                    + ((ROUND != 0) ? NW'(den_w >> 1) : '0);
        prep_dsh[l] = NW'(den_w) << (OUT_W - 1);
      end
      ge[l]    = rem_q[l] >= dsh_q[l];
      q_nxt[l] = OUT_W'({quo_q[l], ge[l]});
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    wt_en   = (state_q == S_WR);
    case (state_q)
      S_IDLE: if (start) state_d = (num_words == '0) ? S_DONE : S_RD;
      S_RD:   state_d = (RD_LAT == 0) ? S_PREP : S_WAIT;
      S_WAIT: if (wait_q == '0) state_d = S_PREP;
      S_PREP: state_d = S_DIV;
      S_DIV:  if (div_q == '0) state_d = S_WR;
      S_WR:   state_d = (words_q == ADDR_W'(1)) ? S_DONE : S_RD;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q      <= 1'b0;
      min_q     <= '0;
      tot_q     <= '0;
      rd_addr_q <= '0;
      wt_addr_q <= '0;
      dst_q     <= '0;
      words_q   <= '0;
      wait_q    <= '0;
      div_q     <= '0;
      data_q    <= '0;
      wt_data_q <= '0;
      for (int l = 0; l < LANES; l++) begin
        rem_q[l] <= '0;
        dsh_q[l] <= '0;
        quo_q[l] <= '0;
      end
    end else begin
      en_q <= enable;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            min_q     <= cdf_min;
            tot_q     <= cdf_total;
            rd_addr_q <= src_base;
            dst_q     <= dst_base;
            words_q   <= num_words;
          end
        end
        S_RD: begin
          if (RD_LAT == 0) data_q <= rd_data;
          else             wait_q <= WW'(RD_LAT - 1);
        end
        S_WAIT: begin
          if (wait_q == '0) data_q <= rd_data;
          else              wait_q <= wait_q - WW'(1);
        end
        S_PREP: begin
          div_q <= CW'(OUT_W - 1);
          for (int l = 0; l < LANES; l++) begin
            rem_q[l] <= prep_rem[l];
            dsh_q[l] <= prep_dsh[l];
            quo_q[l] <= '0;
          end
        end
        S_DIV: begin
          for (int l = 0; l < LANES; l++) begin
            if (ge[l]) rem_q[l] <= rem_q[l] - dsh_q[l];
            dsh_q[l] <= dsh_q[l] >> 1;
            quo_q[l] <= q_nxt[l];
          end
          if (div_q == '0) begin
            wt_addr_q <= dst_q;
            for (int l = 0; l < LANES; l++) begin
              wt_data_q[l*LANE_W +: LANE_W] <= LANE_W'(sat_q(q_nxt[l]));
            end
          end else begin
            div_q <= div_q - CW'(1);
          end
        end
        S_WR: begin
          words_q   <= words_q - ADDR_W'(1);
          dst_q     <= dst_q + ADDR_W'(1);
          rd_addr_q <= rd_addr_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rd_addr = rd_addr_q;
  assign wt_addr = wt_addr_q;
  assign wt_data = wt_data_q;

endmodule

// File: tb/tb_cdf_scale_div_engine.sv
module tb_cdf_scale_div_engine;

  localparam int NG = 3;  // 0: defaults, 1: ROUND=1, 2: RD_LAT=2

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NG-1:0] en;
  logic [31:0]   cdf_min, cdf_total;
  logic [15:0]   src_base, dst_base, num_words;
  logic [15:0]   rd_addr [NG];
  logic [15:0]   wt_addr [NG];
  logic [127:0]  rd_data [NG];
  logic [127:0]  wt_data [NG];
  logic          wt_en [NG];
  logic          busy [NG];
  logic          done [NG];

  logic [127:0]  mem [65536];
  int            cyc = 0;

  typedef struct { int g; int cyc; logic [15:0] a; logic [127:0] d; } wr_t;
  wr_t log_q [$];

  typedef struct { int g; logic [31:0] mn; logic [31:0] tot; logic [127:0] lanes; logic [127:0] exp; } vec_t;
  vec_t tbl [9];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < NG; g++) begin : g_dut
    localparam int LAT = (g == 2) ? 2 : 0;
    localparam int RND = (g == 1) ? 1 : 0;
    logic [127:0] p1, p2;
    always @(posedge clk) begin
      p1 <= mem[rd_addr[g]];
      p2 <= p1;
    end
    assign rd_data[g] = (LAT == 0) ? mem[rd_addr[g]] : p2;

    cdf_scale_div_engine #(.RD_LAT(LAT), .ROUND(RND)) u_dut (
      .clk       (clk),
      .reset     (rst),
      .enable    (en[g]),
      .cdf_min   (cdf_min),
      .cdf_total (cdf_total),
      .src_base  (src_base),
      .dst_base  (dst_base),
      .num_words (num_words),
      .rd_addr   (rd_addr[g]),
      .rd_data   (rd_data[g]),
      .wt_addr   (wt_addr[g]),
      .wt_data   (wt_data[g]),
      .wt_en     (wt_en[g]),
      .busy      (busy[g]),
      .done      (done[g])
    );
  end

  // write log: the edge number at which each strobe is seen
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < NG; g++) begin
      if (wt_en[g]) log_q.push_back('{g, cyc, wt_addr[g], wt_data[g]});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // reference: each lane scaled with plain wide integer arithmetic
  function automatic logic [127:0] model_word(input logic [127:0] w, input logic [31:0] mn,
                                              input logic [31:0] tot, input bit rnd);
    logic [127:0] r;
    longint unsigned c, q, lo, hi;
    r  = '0;
    lo = 64'(mn);
    hi = 64'(tot);
    for (int l = 0; l < 4; l++) begin
      c = 64'(w[l*32 +: 32]);
      if (c <= lo)      q = 0;
      else if (c >= hi) q = 255;
      else begin
        q = ((c - lo) * 255 + (rnd ? (hi - lo) / 2 : 0)) / (hi - lo);
        if (q > 255) q = 255;
      end
      r[l*32 +: 32] = 32'(q);
    end
    return r;
  endfunction

  function automatic logic [127:0] rand_word(input logic [31:0] mn, input logic [31:0] tot);
    logic [127:0] r;
    for (int l = 0; l < 4; l++) begin
      case ($urandom_range(4, 0))
        0:       r[l*32 +: 32] = mn;
        1:       r[l*32 +: 32] = tot;
        2:       r[l*32 +: 32] = $urandom;
        default: r[l*32 +: 32] = $urandom_range(tot + 32'd8, 0);
      endcase
    end
    return r;
  endfunction

  task automatic check_zero(input string nm, input int g);
    chk({nm, "_ctl"},  128'({wt_en[g], busy[g], done[g]}), 128'd0);
    chk({nm, "_addr"}, 128'({rd_addr[g], wt_addr[g]}), 128'd0);
    chk({nm, "_data"}, wt_data[g], 128'd0);
  endtask

  task automatic run_job(input int g, input logic [31:0] mn, input logic [31:0] tot,
                         input logic [15:0] src, input logic [15:0] dst, input int n, input bit hold);
    logic [127:0] exp_d [$];
    int per, k0, dedge;
    bit found, bsy;
    per = 11 + ((g == 2) ? 2 : 0);
    for (int i = 0; i < n; i++) exp_d.push_back(model_word(mem[16'(src + i)], mn, tot, g == 1));
    log_q.delete();
    @(negedge clk);
    cdf_min = mn; cdf_total = tot; src_base = src; dst_base = dst; num_words = 16'(n);
    en[g] = 1'b1;
    @(posedge clk);
    #1;
    k0 = cyc - 1;
    chk("busy_on_accept", 128'(busy[g]), 128'd1);
    // the running job must ignore these
    cdf_min = $urandom; cdf_total = $urandom;
    src_base = 16'($urandom); dst_base = 16'($urandom); num_words = 16'($urandom);
    found = 0; dedge = -1; bsy = 0;
    for (int t = 0; t < n * per + 30 && !found; t++) begin
      @(negedge clk);
      if (done[g]) begin
        found = 1;
        dedge = cyc;
        bsy   = busy[g];
      end
      if (t == 0) en[g] = 1'b0;
      if (t == 1 && hold) en[g] = 1'b1;
    end
    chk("done_seen", 128'(found), 128'd1);
    chk("done_cycle", 128'(dedge), 128'(k0 + n * per + 1));
    chk("busy_at_done", 128'(bsy), 128'd1);
    @(negedge clk);
    chk("done_pulse_end", 128'({busy[g], done[g]}), 128'd0);
    if (hold) begin
      repeat (25) @(negedge clk);
      chk("no_retrigger", 128'(busy[g]), 128'd0);
      en[g] = 1'b0;
    end
    chk("write_count", 128'(log_q.size()), 128'(n));
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      chk("wr_addr",  128'(log_q[i].a), 128'(16'(dst + i)));
      chk("wr_data",  log_q[i].d, exp_d[i]);
      chk("wr_cycle", 128'(log_q[i].cyc), 128'(k0 + (i + 1) * per));
    end
  endtask

  initial begin
    int k0;
    rst = 1'b1; en = '0;
    cdf_min = '0; cdf_total = '0; src_base = '0; dst_base = '0; num_words = '0;

    //          g  min     total          lanes {l3,l2,l1,l0}                                            expected
    tbl[0] = '{0, 32'd18, 32'h12C1,     {4{32'h961}},                                                   {4{32'd127}}};
    tbl[1] = '{0, 32'd18, 32'h12C1,     {32'h2000, 32'h12C1, 32'd5, 32'd18},                            {32'd255, 32'd255, 32'd0, 32'd0}};
    tbl[2] = '{0, 32'd0,  32'd256,      {32'd200, 32'd128, 32'd255, 32'd1},                             {32'd199, 32'd127, 32'd254, 32'd0}};
    tbl[3] = '{0, 32'd100, 32'd50,      {32'd50, 32'd0, 32'd101, 32'd100},                              {32'd0, 32'd0, 32'd255, 32'd0}};
    tbl[4] = '{0, 32'd0,  32'hFFFFFFFF, {32'hFFFFFFFE, 32'h80000000, 32'h7FFFFFFF, 32'd1},              {32'd254, 32'd127, 32'd127, 32'd0}};
    tbl[5] = '{0, 32'd0,  32'd10,       {32'd3, 32'd5, 32'd9, 32'd1},                                   {32'd76, 32'd127, 32'd229, 32'd25}};
    tbl[6] = '{1, 32'd0,  32'd10,       {32'd3, 32'd5, 32'd9, 32'd1},                                   {32'd77, 32'd128, 32'd230, 32'd26}};
    tbl[7] = '{2, 32'd18, 32'h12C1,     {4{32'h961}},                                                   {4{32'd127}}};
    tbl[8] = '{0, 32'd18, 32'h12C1,     {32'd4800, 32'd19, 32'h12C1, 32'd18},                           {32'd254, 32'd0, 32'd255, 32'd0}};

    repeat (3) @(negedge clk);
    for (int g = 0; g < NG; g++) check_zero("reset_state", g);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      mem[16'h0200 + 16'(k)] = tbl[k].lanes;
      run_job(tbl[k].g, tbl[k].mn, tbl[k].tot, 16'h0200 + 16'(k), 16'h1000 + 16'(k), 1, 1'b0);
      chk("table_result", (log_q.size() == 1) ? log_q[0].d : '1, tbl[k].exp);
    end

    // address wrap, zero-length job, in-place job, enable edge during busy
    mem[16'hFFFE] = {32'd10, 32'd20, 32'd30, 32'd40};
    mem[16'hFFFF] = {32'd50, 32'd60, 32'd70, 32'd80};
    mem[16'h0000] = {32'd90, 32'd100, 32'd110, 32'd120};
    mem[16'h0001] = {32'd130, 32'd140, 32'd150, 32'd250};
    run_job(0, 32'd5, 32'd256, 16'hFFFE, 16'h7FFE, 4, 1'b0);
    run_job(0, 32'd18, 32'h12C1, 16'h0000, 16'h0000, 0, 1'b0);
    for (int i = 0; i < 3; i++) mem[16'h0300 + 16'(i)] = rand_word(32'd18, 32'h12C1);
    run_job(0, 32'd18, 32'h12C1, 16'h0300, 16'h0300, 3, 1'b0);
    run_job(0, 32'd18, 32'h12C1, 16'h0300, 16'h0380, 2, 1'b1);

    // reset in the divide phase of the second word, then a clean rerun
    for (int i = 0; i < 4; i++) mem[16'h0400 + 16'(i)] = rand_word(32'd18, 32'h12C1);
    log_q.delete();
    @(negedge clk);
    cdf_min = 32'd18; cdf_total = 32'h12C1; src_base = 16'h0400; dst_base = 16'h0500;
    num_words = 16'd4; en[0] = 1'b1;
    @(posedge clk);
    #1;
    k0 = cyc - 1;
    @(negedge clk);
    en[0] = 1'b0;
    while (cyc <= k0 + 15) @(negedge clk);
    chk("busy_before_reset", 128'(busy[0]), 128'd1);
    #1 rst = 1'b1;
    #1 check_zero("mid_job_reset", 0);
    chk("writes_before_reset", 128'(log_q.size()), 128'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("writes_after_reset", 128'(log_q.size()), 128'd1);
    chk("idle_after_reset", 128'(busy[0]), 128'd0);
    run_job(0, 32'd18, 32'h12C1, 16'h0400, 16'h0500, 4, 1'b0);

    // randomized jobs against the reference model
    for (int r = 0; r < 24; r++) begin
      int g, n, mode;
      logic [31:0] mn, tot;
      logic [15:0] src;
      g = r % NG;
      n = $urandom_range(3, 1);
      mode = $urandom_range(2, 0);
      if (mode == 0) begin
        mn = $urandom_range(1000, 0);
        tot = mn + $urandom_range(5000, 1);
      end else if (mode == 1) begin
        mn = $urandom;
        tot = $urandom;
      end else begin
        mn = 32'd0;
        tot = $urandom_range(20, 1);
      end
      src = 16'($urandom);
      for (int i = 0; i < n; i++) mem[16'(src + i)] = rand_word(mn, tot);
      run_job(g, mn, tot, src, src ^ 16'h8000, n, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
